// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package reg_file_pkg;

  localparam int unsigned DefaultDataWidth = 32;
  localparam int unsigned DefaultAddrWidth = 5;
  localparam int unsigned DefaultNumRead   = 2;

  // Register that reads as zero when the zero register is enabled
  localparam int unsigned ZeroRegAddr = 0;

  // Widest packed vector / field the slicing helper supports
  localparam int unsigned MaxPackedWidth = 256;
  localparam int unsigned MaxFieldWidth  = 64;

  // Extract field 'port' of 'width' bits from a packed per-port vector
  function automatic logic [MaxFieldWidth-1:0] port_field(
    input logic [MaxPackedWidth-1:0] vec,
    input int unsigned               port,
    input int unsigned               width
  );
    logic [MaxPackedWidth-1:0] shifted;
    logic [MaxFieldWidth-1:0]  mask;
    shifted = vec >> (port * width);
    mask    = (MaxFieldWidth'(1) << width) - MaxFieldWidth'(1);
    return shifted[MaxFieldWidth-1:0] & mask;
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Read/write/reservation bus of the scoreboarded register file.
interface reg_file_sb_if
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
  parameter int unsigned NUM_READ   = DefaultNumRead
);

  logic                           read;
  logic [NUM_READ*ADDR_WIDTH-1:0] addr_r;
  logic [NUM_READ*DATA_WIDTH-1:0] data_r;
  logic [NUM_READ-1:0]            busy_r;
  logic                           write;
  logic [ADDR_WIDTH-1:0]          addr_w;
  logic [DATA_WIDTH-1:0]          data_w;
  logic                           reserve;
  logic [ADDR_WIDTH-1:0]          addr_rsv;
  logic                           pending;

  modport master (
    output read, addr_r, write, addr_w, data_w, reserve, addr_rsv,
    input  data_r, busy_r, pending
  );

  modport slave (
    input  read, addr_r, write, addr_w, data_w, reserve, addr_rsv,
    output data_r, busy_r, pending
  );

endinterface

// File: rtl/reg_file_read_port.sv
// One registered read port: array mux, write bypass and zero-register override.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         read,
  input  logic [ADDR_WIDTH-1:0]                        addr,
  input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0]     mem,
  input  logic [2**ADDR_WIDTH-1:0]                     busy,
  input  logic                                         write,
  input  logic [ADDR_WIDTH-1:0]                        addr_w,
  input  logic [DATA_WIDTH-1:0]                        data_w,
  output logic [DATA_WIDTH-1:0]                        data_r,
  output logic                                         busy_r
);

  logic                  is_zero;
  logic                  hit;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  busy_d;

  // Select stored or forwarded data; a forwarded write also retires the busy bit
  always_comb begin
    is_zero = ZERO_REG && (addr == ADDR_WIDTH'(ZeroRegAddr));
    hit     = BYPASS && write && (addr_w == addr) && !is_zero;
    data_d  = hit ? data_w : mem[addr];
    busy_d  = busy[addr] && !hit;
    if (is_zero) begin
      data_d = '0;
      busy_d = 1'b0;
    end
  end

  // Output registers update only on READ, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= '0;
      busy_r <= 1'b0;
    end else if (read) begin
      data_r <= data_d;
      busy_r <= busy_d;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with per-register write-pending scoreboard.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
  parameter int unsigned NUM_READ   = DefaultNumRead,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b1
) (
  input logic          clk,
  input logic          rst,
  reg_file_sb_if.slave bus
);

  localparam int unsigned Depth = 2**ADDR_WIDTH;

  logic [Depth-1:0][DATA_WIDTH-1:0]    mem_q;
  logic [Depth-1:0]                    busy_q;
  logic [Depth-1:0]                    busy_d;
  logic                                wr_en;
  logic [NUM_READ-1:0][DATA_WIDTH-1:0] data_r_all;
  logic [NUM_READ-1:0]                 busy_r_all;

  assign wr_en = bus.write && !(ZERO_REG && (bus.addr_w == ADDR_WIDTH'(ZeroRegAddr)));

  // Storage write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else if (wr_en) begin
      mem_q[bus.addr_w] <= bus.data_w;
    end
  end

  // Busy next state: writeback clears, then a reservation sets (new producer wins)
  always_comb begin
    busy_d = busy_q;
    if (bus.write) busy_d[bus.addr_w] = 1'b0;
    if (bus.reserve) busy_d[bus.addr_rsv] = 1'b1;
    if (ZERO_REG) busy_d[ZeroRegAddr] = 1'b0;
  end

  // Busy register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign bus.pending = |busy_q;

  for (genvar p = 0; p < NUM_READ; p++) begin : g_read
    reg_file_read_port #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .ZERO_REG  (ZERO_REG),
      .BYPASS    (BYPASS)
    ) u_read_port (
      .clk   (clk),
      .rst   (rst),
      .read  (bus.read),
      .addr  (ADDR_WIDTH'(port_field(MaxPackedWidth'(bus.addr_r), p, ADDR_WIDTH))),
      .mem   (mem_q),
      .busy  (busy_q),
      .write (bus.write),
      .addr_w(bus.addr_w),
      .data_w(bus.data_w),
      .data_r(data_r_all[p]),
      .busy_r(busy_r_all[p])
    );
  end

  assign bus.data_r = data_r_all;
  assign bus.busy_r = busy_r_all;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench: default instance, a no-bypass instance and a narrow 3-port instance.
module tb_reg_file_sb;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  reg_file_sb_if ia ();
  reg_file_sb_if ib ();
  reg_file_sb_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_READ(3)) ic ();

  reg_file_sb dut_a (
    .clk(clk),
    .rst(rst),
    .bus(ia)
  );

  reg_file_sb #(.BYPASS(1'b0)) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(ib)
  );

  reg_file_sb #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_READ(3)) dut_c (
    .clk(clk),
    .rst(rst),
    .bus(ic)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ia.read = 0; ia.addr_r = '0; ia.write = 0; ia.addr_w = '0; ia.data_w = '0;
    ia.reserve = 0; ia.addr_rsv = '0;
    ib.read = 0; ib.addr_r = '0; ib.write = 0; ib.addr_w = '0; ib.data_w = '0;
    ib.reserve = 0; ib.addr_rsv = '0;
    ic.read = 0; ic.addr_r = '0; ic.write = 0; ic.addr_w = '0; ic.data_w = '0;
    ic.reserve = 0; ic.addr_rsv = '0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_data", 64'(ia.data_r), 64'h0);
    check("rst_busy", 64'(ia.busy_r), 64'h0);
    check("rst_pending", 64'(ia.pending), 64'h0);

    // Basic write then read of r3 / r31
    ia.write = 1; ia.addr_w = 5'd3; ia.data_w = 32'h1234_5678;
    tick();
    ia.addr_w = 5'd31; ia.data_w = 32'hA5A5_A5A5;
    tick();
    ia.write = 0; ia.read = 1; ia.addr_r = {5'd31, 5'd3};
    tick();
    check("basic_read", 64'(ia.data_r), 64'hA5A5_A5A5_1234_5678);
    check("basic_busy", 64'(ia.busy_r), 64'h0);
    ia.read = 0; ia.addr_r = {5'd0, 5'd0};
    tick();
    check("read_hold", 64'(ia.data_r), 64'hA5A5_A5A5_1234_5678);

    // Bypass vs no bypass: preload r9 on ib, then same-cycle write+read
    ib.write = 1; ib.addr_w = 5'd9; ib.data_w = 32'h0000_1111;
    tick();
    ia.write = 1; ia.addr_w = 5'd9; ia.data_w = 32'h0000_CAFE;
    ia.read = 1; ia.addr_r = {5'd3, 5'd9};
    ib.write = 1; ib.addr_w = 5'd9; ib.data_w = 32'h0000_CAFE;
    ib.read = 1; ib.addr_r = {5'd0, 5'd9};
    tick();
    check("bypass_on", 64'(ia.data_r), 64'h1234_5678_0000_CAFE);
    check("bypass_off_old", 64'(ib.data_r[31:0]), 64'h0000_1111);
    ia.write = 0; ib.write = 0;
    tick();
    check("bypass_off_next", 64'(ib.data_r[31:0]), 64'h0000_CAFE);

    // Zero register ignores writes and reservations
    ia.write = 1; ia.addr_w = 5'd0; ia.data_w = 32'hFFFF_FFFF;
    ia.reserve = 1; ia.addr_rsv = 5'd0; ia.read = 0;
    tick();
    ia.write = 0; ia.reserve = 0; ia.read = 1; ia.addr_r = {5'd0, 5'd0};
    tick();
    check("zero_data", 64'(ia.data_r), 64'h0);
    check("zero_busy", 64'(ia.busy_r), 64'h0);
    check("zero_pending", 64'(ia.pending), 64'h0);

    // Scoreboard: reserve r4
    ia.read = 0; ia.reserve = 1; ia.addr_rsv = 5'd4;
    ib.read = 0; ib.reserve = 1; ib.addr_rsv = 5'd4;
    tick();
    ia.reserve = 0; ib.reserve = 0;
    check("rsv_pending", 64'(ia.pending), 64'h1);
    ia.read = 1; ia.addr_r = {5'd0, 5'd4};
    tick();
    check("rsv_busy_r", 64'(ia.busy_r), 64'h1);
    // Writeback of r4 while reading it
    ia.write = 1; ia.addr_w = 5'd4; ia.data_w = 32'h0000_0044;
    ib.write = 1; ib.addr_w = 5'd4; ib.data_w = 32'h0000_0044;
    ib.read = 1; ib.addr_r = {5'd0, 5'd4};
    tick();
    check("wb_busy_bypass", 64'(ia.busy_r), 64'h0);
    check("wb_data_bypass", 64'(ia.data_r[31:0]), 64'h0000_0044);
    check("wb_pending", 64'(ia.pending), 64'h0);
    check("wb_busy_nobypass", 64'(ib.busy_r), 64'h1);
    check("wb_pending_b", 64'(ib.pending), 64'h0);
    ib.write = 0; ib.read = 0;
    // Same-cycle reserve and write of r4: reservation wins
    ia.reserve = 1; ia.addr_rsv = 5'd4; ia.read = 0;
    tick();
    ia.write = 0; ia.reserve = 0; ia.read = 1;
    tick();
    check("rsv_wr_busy", 64'(ia.busy_r), 64'h1);
    check("rsv_wr_pending", 64'(ia.pending), 64'h1);

    // Narrow three-port instance
    ic.write = 1; ic.addr_w = 3'd7; ic.data_w = 16'hBEEF;
    tick();
    ic.write = 0; ic.read = 1; ic.addr_r = {3'd7, 3'd7, 3'd7};
    tick();
    check("param_read", 64'(ic.data_r), 64'hBEEF_BEEF_BEEF);

    // Asynchronous reset mid-operation
    ia.write = 1; ia.addr_w = 5'd5; ia.data_w = 32'hDEAD_BEEF; ia.read = 0;
    tick();
    ia.write = 0; ia.reserve = 1; ia.addr_rsv = 5'd7;
    ia.read = 1; ia.addr_r = {5'd0, 5'd5};
    tick();
    ia.reserve = 0;
    check("pre_rst_data", 64'(ia.data_r[31:0]), 64'hDEAD_BEEF);
    check("pre_rst_pending", 64'(ia.pending), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_data", 64'(ia.data_r), 64'h0);
    check("async_rst_busy", 64'(ia.busy_r), 64'h0);
    check("async_rst_pending", 64'(ia.pending), 64'h0);
    rst = 1'b0;
    tick();
    check("post_rst_r5", 64'(ia.data_r[31:0]), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
